// File: rtl/round_robin.sv
// Round-robin N:1 stream scheduler: one registered word per grant, plus the granted index on a side stream.
// Latency 1 cycle; a new grant needs both output streams empty or draining, so each stream may stall the sources.
module round_robin #(
    parameter int  W  = 16,
    parameter int  N  = 2,
    localparam int IW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    s_stb,
    input  logic [N*W-1:0]  s_dat,
    output logic [N-1:0]    s_rdy,
    input  logic            n_rdy,
    output logic            n_stb,
    output logic [IW-1:0]   n_dat,
    input  logic            m_rdy,
    output logic            m_stb,
    output logic [W-1:0]    m_dat
);

    logic [IW-1:0] ptr;
    logic [IW-1:0] grant;
    logic [IW-1:0] ptr_nxt;
    logic          load;

    // First requester at or after ptr, wrapping past N-1 back to 0.
    always_comb begin
        logic found;
        found = 1'b0;
        grant = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && s_stb[(int'(ptr) + k) % N]) begin
                found = 1'b1;
                grant = IW'((int'(ptr) + k) % N);
            end
        end
    end

    assign load    = (~m_stb | m_rdy) & (~n_stb | n_rdy) & ~rst & (|s_stb);
    assign s_rdy   = load ? (N'(1) << grant) : '0;
    assign ptr_nxt = (grant == IW'(N - 1)) ? '0 : grant + IW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr   <= '0;
            m_stb <= 1'b0;
            n_stb <= 1'b0;
            m_dat <= '0;
            n_dat <= '0;
        end else if (load) begin
            ptr   <= ptr_nxt;
            m_stb <= 1'b1;
            n_stb <= 1'b1;
            m_dat <= s_dat[grant*W +: W];
            n_dat <= grant;
        end else begin
            // The two streams drain independently while the stage waits.
            m_stb <= m_stb & ~m_rdy;
            n_stb <= n_stb & ~n_rdy;
        end
    end

endmodule
